// File: rtl/kalman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kalman_pkg
// Description : Shared definitions for the Kalman state-update datapath:
//               FSM state encoding, accumulator-width function and the
//               floor-shift / saturation helpers used by the MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package kalman_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRED  = 3'd1,
        S_INNOV = 3'd2,
        S_CORR  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Wide enough for the longest dot product plus one bias term.
    function automatic int acc_w(input int width, input int nos, input int noi);
        return 2 * width + $clog2(nos + noi + 1);
    endfunction

    // Largest / smallest value representable in a signed word of 'width' bits.
    function automatic longint sat_hi(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // Arithmetic shift: drops fraction bits rounding toward minus infinity.
    function automatic longint floor_shift(input longint v, input int frac);
        return v >>> frac;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kalman_mac.sv
`default_nettype none
// ============================================================================
// Module      : kalman_mac
// Description : Signed multiply-accumulate. The first term of a dot product
//               (i_clr) starts from i_bias instead of the running sum, so a
//               pre-scaled additive term costs no extra cycle. o_result is the
//               running sum (including this cycle's term) shifted down by FRAC
//               and saturated to WIDTH; o_ovf flags that saturation occurred.
// Ports       : clk, reset (async, active-low)
//               i_en    - accumulate this cycle
//               i_clr   - first term: start from i_bias
//               i_sub   - subtract the product instead of adding it
//               i_a/i_b - WIDTH-bit signed operands
//               i_bias  - ACC_W-bit starting value (already scaled by 2^FRAC)
//               o_result, o_ovf - combinational shifted/saturated result
// Revision    : 1.0 - initial release
// ============================================================================
module kalman_mac
    import kalman_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 35
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic                    i_sub,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic signed [ACC_W-1:0] i_bias,
    output logic signed [WIDTH-1:0] o_result,
    output logic                    o_ovf
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [63:0]      w_shift;
    logic                    w_hi;
    logic                    w_lo;

    always_comb begin
        w_prod   = ACC_W'(i_a) * ACC_W'(i_b);
        w_term   = i_sub ? -w_prod : w_prod;
        w_sum    = (i_clr ? i_bias : r_acc) + w_term;
        w_shift  = floor_shift(64'(w_sum), FRAC);
        w_hi     = (w_shift > sat_hi(WIDTH));
        w_lo     = (w_shift < sat_lo(WIDTH));
        o_ovf    = w_hi | w_lo;
        o_result = w_hi ? WIDTH'(sat_hi(WIDTH)) :
                   w_lo ? WIDTH'(sat_lo(WIDTH)) : w_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/kalman_state_update.sv
`default_nettype none
// ============================================================================
// Module      : kalman_state_update
// Description : Sequential Kalman state update using one shared MAC.
//               PRED  : xp = A*x + B*U      (NOS rows of NOS+NOI terms)
//               INNOV : e  = Y - H*xp       (NOO rows of NOS terms)
//               CORR  : xn = xp + K*e       (NOS rows of NOO terms)
//               Predict-only runs skip INNOV/CORR. x_nk and the internal
//               prior are updated on the edge that raises done.
// Ports       : clk, reset (async, active-low)
//               A, B, H, K, U, Y - model matrices/vectors (hold while busy)
//               X_0, load_x0     - prior load in IDLE
//               start, meas_valid- run request (meas_valid captured at start)
//               busy, done, sat  - status; x_nk - registered estimate
// Revision    : 1.0 - initial release
// ============================================================================
module kalman_state_update
    import kalman_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int NOS   = 4,
    parameter int NOO   = 2,
    parameter int NOI   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] A   [NOS][NOS],
    input  logic signed [WIDTH-1:0] B   [NOS][NOI],
    input  logic signed [WIDTH-1:0] H   [NOO][NOS],
    input  logic signed [WIDTH-1:0] K   [NOS][NOO],
    input  logic signed [WIDTH-1:0] U   [NOI],
    input  logic signed [WIDTH-1:0] Y   [NOO],
    input  logic signed [WIDTH-1:0] X_0 [NOS],
    input  logic                    load_x0,
    input  logic                    start,
    input  logic                    meas_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sat,
    output logic signed [WIDTH-1:0] x_nk [NOS]
);

    localparam int c_ACC_W = acc_w(WIDTH, NOS, NOI);
    localparam int c_CNT_W = $clog2(NOS + NOI + NOO + 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_CNT_W-1:0]      r_row;
    logic [c_CNT_W-1:0]      r_col;
    logic [c_CNT_W-1:0]      w_col_last;
    logic [c_CNT_W-1:0]      w_row_last;
    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_mac_en;
    logic                    r_meas;
    logic                    r_done;
    logic                    r_sat;
    logic signed [WIDTH-1:0] r_x  [NOS];
    logic signed [WIDTH-1:0] r_xp [NOS];
    logic signed [WIDTH-1:0] r_e  [NOO];
    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_b;
    logic signed [c_ACC_W-1:0] w_bias;
    logic                    w_sub;
    logic signed [WIDTH-1:0] w_result;
    logic                    w_ovf;

    assign done       = r_done;
    assign sat        = r_sat;
    assign w_last_col = (r_col == w_col_last);
    assign w_last_row = (r_row == w_row_last);

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_PRED;
            S_PRED:  if (w_last_col && w_last_row)
                         w_state_next = r_meas ? S_INNOV : S_DONE;
            S_INNOV: if (w_last_col && w_last_row) w_state_next = S_CORR;
            S_CORR:  if (w_last_col && w_last_row) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand selection for the shared MAC. The additive terms (Y in INNOV,
    // xp in CORR) enter as the pre-scaled bias of each row's first term.
    // ------------------------------------------------------------------------
    always_comb begin
        w_a        = '0;
        w_b        = '0;
        w_bias     = '0;
        w_sub      = 1'b0;
        w_mac_en   = 1'b0;
        w_col_last = '0;
        w_row_last = '0;
        unique case (r_state)
            S_PRED: begin
                w_mac_en   = 1'b1;
                w_col_last = c_CNT_W'(NOS + NOI - 1);
                w_row_last = c_CNT_W'(NOS - 1);
                for (int i = 0; i < NOS; i++) begin
                    if (r_row == c_CNT_W'(i)) begin
                        for (int j = 0; j < NOS; j++) begin
                            if (r_col == c_CNT_W'(j)) begin
                                w_a = A[i][j];
                                w_b = r_x[j];
                            end
                        end
                        for (int j = 0; j < NOI; j++) begin
                            if (r_col == c_CNT_W'(NOS + j)) begin
                                w_a = B[i][j];
                                w_b = U[j];
                            end
                        end
                    end
                end
            end
            S_INNOV: begin
                w_mac_en   = 1'b1;
                w_sub      = 1'b1;
                w_col_last = c_CNT_W'(NOS - 1);
                w_row_last = c_CNT_W'(NOO - 1);
                for (int i = 0; i < NOO; i++) begin
                    if (r_row == c_CNT_W'(i)) begin
                        w_bias = c_ACC_W'(Y[i]) <<< FRAC;
                        for (int j = 0; j < NOS; j++) begin
                            if (r_col == c_CNT_W'(j)) begin
                                w_a = H[i][j];
                                w_b = r_xp[j];
                            end
                        end
                    end
                end
            end
            S_CORR: begin
                w_mac_en   = 1'b1;
                w_col_last = c_CNT_W'(NOO - 1);
                w_row_last = c_CNT_W'(NOS - 1);
                for (int i = 0; i < NOS; i++) begin
                    if (r_row == c_CNT_W'(i)) begin
                        w_bias = c_ACC_W'(r_xp[i]) <<< FRAC;
                        for (int j = 0; j < NOO; j++) begin
                            if (r_col == c_CNT_W'(j)) begin
                                w_a = K[i][j];
                                w_b = r_e[j];
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    kalman_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (c_ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_mac_en),
        .i_clr    (r_col == '0),
        .i_sub    (w_sub),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_bias   (w_bias),
        .o_result (w_result),
        .o_ovf    (w_ovf)
    );

    // ------------------------------------------------------------------------
    // State, counters, scratch and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_meas  <= 1'b0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            for (int i = 0; i < NOS; i++) begin
                r_x[i]  <= '0;
                r_xp[i] <= '0;
                x_nk[i] <= '0;
            end
            for (int i = 0; i < NOO; i++) begin
                r_e[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;

            if (r_state == S_IDLE) begin
                r_row <= '0;
                r_col <= '0;
                // Load takes effect before PRED reads the prior, so a
                // simultaneous start runs from X_0.
                if (load_x0) begin
                    for (int i = 0; i < NOS; i++) begin
                        r_x[i] <= X_0[i];
                    end
                end
                if (start) begin
                    r_meas <= meas_valid;
                    r_sat  <= 1'b0;
                end
            end

            if (w_mac_en) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + c_CNT_W'(1);
                    if (w_ovf) begin
                        r_sat <= 1'b1;
                    end
                    // CORR overwrites xp[i] in place: its bias was consumed
                    // on this row's first term and no later row reads it.
                    for (int i = 0; i < NOS; i++) begin
                        if (r_row == c_CNT_W'(i) && r_state != S_INNOV) begin
                            r_xp[i] <= w_result;
                        end
                    end
                    for (int i = 0; i < NOO; i++) begin
                        if (r_row == c_CNT_W'(i) && r_state == S_INNOV) begin
                            r_e[i] <= w_result;
                        end
                    end
                end else begin
                    r_col <= r_col + c_CNT_W'(1);
                end
            end

            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                for (int i = 0; i < NOS; i++) begin
                    x_nk[i] <= r_xp[i];
                    r_x[i]  <= r_xp[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kalman_state_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_kalman_state_update
// Description : Scoreboard bench for kalman_state_update (16/8, 4 states,
//               2 outputs, 2 inputs). The driver pushes the expected x_nk,
//               sat and done cycle for every accepted start; a monitor pops
//               and compares whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kalman_state_update;

    typedef struct packed {
        logic [63:0] x;
        logic        sat;
        logic [31:0] cyc;
    } exp_t;

    logic clk;
    logic reset;
    logic signed [15:0] A   [4][4];
    logic signed [15:0] B   [4][2];
    logic signed [15:0] H   [2][4];
    logic signed [15:0] K   [4][2];
    logic signed [15:0] U   [2];
    logic signed [15:0] Y   [2];
    logic signed [15:0] X_0 [4];
    logic load_x0;
    logic start;
    logic meas_valid;
    logic busy;
    logic done;
    logic sat;
    logic signed [15:0] x_nk [4];

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    kalman_state_update #(
        .WIDTH (16), .FRAC (8), .NOS (4), .NOO (2), .NOI (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .H          (H),
        .K          (K),
        .U          (U),
        .Y          (Y),
        .X_0        (X_0),
        .load_x0    (load_x0),
        .start      (start),
        .meas_valid (meas_valid),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .x_nk       (x_nk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("x_nk[%0d]", k), x_nk[k], signed'(e.x[16*k +: 16]));
                end
                chk("sat", sat, e.sat);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic clear_mats();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) A[i][j] = '0;
            for (int j = 0; j < 2; j++) begin
                B[i][j] = '0;
                K[i][j] = '0;
                H[j][i] = '0;
            end
            X_0[i] = '0;
        end
        for (int j = 0; j < 2; j++) begin
            U[j] = '0;
            Y[j] = '0;
        end
    endtask

    task automatic set_diag(input int v);
        for (int i = 0; i < 4; i++) A[i][i] = 16'(v);
    endtask

    // Caller positions time just after a negedge.
    task automatic issue(input logic meas, input logic load, input logic [63:0] ex,
                         input logic esat, input int t);
        start      = 1'b1;
        meas_valid = meas;
        load_x0    = load;
        @(posedge clk);
        #1;
        start      = 1'b0;
        load_x0    = 1'b0;
        meas_valid = 1'b0;
        q.push_back('{x: ex, sat: esat, cyc: 32'(cyc + t + 1)});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic run(input logic meas, input logic load, input logic [63:0] ex,
                       input logic esat, input int t);
        @(negedge clk);
        issue(meas, load, ex, esat, t);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        load_x0    = 1'b0;
        meas_valid = 1'b0;
        clear_mats();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sat", sat, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset_x_nk[%0d]", k), x_nk[k], 0);

        // Identity predict-only, start on the first edge after release.
        reset = 1'b1;
        set_diag(256);
        X_0[0] = 256; X_0[1] = 512; X_0[2] = 768; X_0[3] = 1024;
        issue(1'b0, 1'b1, pk(256, 512, 768, 1024), 1'b0, 24);
        wait_done();

        // Control input on state 0, prior carried over.
        B[0][0] = 256; U[0] = 512;
        run(1'b0, 1'b0, pk(768, 512, 768, 1024), 1'b0, 24);

        // Measurement update with half gain.
        clear_mats();
        set_diag(256);
        X_0[0] = 256;
        H[0][0] = 256; H[1][1] = 256;
        K[0][0] = 128; K[1][1] = 128;
        Y[0] = 1024;
        run(1'b1, 1'b1, pk(640, 0, 0, 0), 1'b0, 40);

        // Fractional gains, floor rounding on negatives, cross term.
        clear_mats();
        A[0][0] = 128; A[1][1] = 128; A[2][2] = 128; A[3][3] = 256; A[3][0] = 256;
        X_0[0] = -3; X_0[1] = 100; X_0[2] = 3;
        run(1'b0, 1'b1, pk(-2, 50, 1, -3), 1'b0, 24);

        // Negative innovation, gains into unobserved states.
        clear_mats();
        set_diag(256);
        H[0][0] = 256; H[1][1] = 256;
        K[0][0] = 256; K[1][1] = 256; K[2][0] = 128; K[3][1] = 64;
        Y[0] = 256; Y[1] = 512;
        X_0[0] = 512; X_0[1] = 256;
        run(1'b1, 1'b1, pk(256, 512, -128, 64), 1'b0, 40);

        // Saturation in both directions.
        clear_mats();
        set_diag(512);
        X_0[0] = 25600; X_0[1] = -25600; X_0[3] = 100;
        run(1'b0, 1'b1, pk(32767, -32768, 0, 200), 1'b1, 24);

        // Non-overflowing run clears sat.
        set_diag(256);
        run(1'b0, 1'b0, pk(32767, -32768, 0, 200), 1'b0, 24);

        // Start pulses while busy are ignored.
        B[0][0] = 256; U[0] = -256;
        @(negedge clk);
        issue(1'b0, 1'b0, pk(32511, -32768, 0, 200), 1'b0, 24);
        repeat (5) @(negedge clk);
        chk("busy_mid_run", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (60) @(negedge clk);

        // Reset in the middle of PRED: no done from the aborted run.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrun_busy", busy, 0);
        chk("midrun_done", done, 0);
        chk("midrun_sat", sat, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("midrun_x_nk[%0d]", k), x_nk[k], 0);
        @(negedge clk);
        reset = 1'b1;
        clear_mats();
        set_diag(256);
        X_0[0] = 256; X_0[1] = 512; X_0[2] = 768; X_0[3] = 1024;
        issue(1'b0, 1'b1, pk(256, 512, 768, 1024), 1'b0, 24);
        wait_done();
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kalman_state_update.md
KALMAN_STATE_UPDATE -- requirements
Module: kalman_state_update

Interface
REQ-001 Parameter WIDTH, default 16: signed fixed-point word width.
REQ-002 Parameter FRAC, default 8: fraction bits (Q(WIDTH-FRAC).FRAC).
REQ-003 Parameter NOS, default 4: number of states.
REQ-004 Parameter NOO, default 2: number of outputs.
REQ-005 Parameter NOI, default 2: number of inputs.
REQ-006 clk  in  1: single clock; all state changes on rising edge.
REQ-007 reset  in  1: asynchronous, active-low reset.
REQ-008 A  in  WIDTH[NOS][NOS]: state transition matrix.
REQ-009 B  in  WIDTH[NOS][NOI]: input matrix.
REQ-010 H  in  WIDTH[NOO][NOS]: observation matrix.
REQ-011 K  in  WIDTH[NOS][NOO]: Kalman gain.
REQ-012 U  in  WIDTH[NOI]: control input.
REQ-013 Y  in  WIDTH[NOO]: measurement.
REQ-014 X_0  in  WIDTH[NOS]: initial state.
REQ-015 load_x0  in  1: in IDLE, load X_0 into internal state.
REQ-016 start  in  1: request one update; sampled only in IDLE.
REQ-017 meas_valid  in  1: captured with start; 0 = predict-only.
REQ-018 busy  out  1: high in any state other than IDLE.
REQ-019 done  out  1: one-cycle pulse when x_nk updated.
REQ-020 sat  out  1: sticky; set if any result saturated during the run, cleared at next accepted start.
REQ-021 x_nk  out  WIDTH[NOS]: registered state estimate.

Function
REQ-022 Computes xp = A*x + B*U; if meas_valid: e = Y - H*xp, x_nk = xp + K*e; else x_nk = xp.
REQ-023 FSM states IDLE, PRED, INNOV, CORR, DONE; IDLE->PRED on start; PRED->INNOV (meas_valid) or ->DONE; INNOV->CORR; CORR->DONE; DONE->IDLE unconditionally.
REQ-024 One signed WIDTHxWIDTH multiply-accumulate per cycle; PRED takes NOS*(NOS+NOI) cycles, INNOV NOO*NOS, CORR NOS*NOO.
REQ-025 Accumulator width 2*WIDTH+clog2(NOS+NOI+1); element result = accumulator arithmetic-shifted right by FRAC, truncation toward -inf, saturated to WIDTH.
REQ-026 Row result written to its scratch register on the row's last term cycle; the intermediate xp and e are held internally, never exposed.
REQ-027 done asserted exactly T+1 cycles after the start-accept edge, T = total MAC cycles; x_nk and internal state updated on the same edge done rises.
REQ-028 Matrix, U and Y inputs must stay stable while busy; meas_valid is captured at start.
REQ-029 start while busy ignored; start and load_x0 same IDLE cycle: X_0 loaded, run uses X_0 as prior.
REQ-030 Successive runs use previous x_nk as prior (no reload required).

Reset
REQ-031 Asserted reset: FSM to IDLE, x_nk, internal state, scratch, accumulator, sat, done, busy all 0, at any time including mid-run.
REQ-032 Deassertion: first start is honoured on the first rising edge after reset releases.

Structure
REQ-033 Shared package kalman_pkg holds FSM state enum, ACC_W function and saturate/round helpers.
REQ-034 One sub-module, kalman_mac: signed MAC with clear, enable and saturating FRAC shift output.

Verification (WIDTH=16, FRAC=8, NOS=4, NOO=2, NOI=2; 1.0=256)
REQ-035 Reset mid-PRED -> busy=0, done=0, x_nk={0,0,0,0} immediately; no done afterward.
REQ-036 load_x0 X_0={256,512,768,1024}, A=I, B=0, start, meas_valid=0 -> done at cycle 25, x_nk unchanged.
REQ-037 Same, B[0][0]=256, U={512,0} -> x_nk[0]=768, others unchanged.
REQ-038 X_0={256,0,0,0}, A=I, B=0, H=[I2|0], K[0][0]=K[1][1]=128 else 0, Y={1024,0}, meas_valid=1 -> done at cycle 41, x_nk[0]=640.
REQ-039 x={25600,...}, A=512*I -> x_nk[0]=32767, sat=1; next run without overflow clears sat.
REQ-040 start pulsed during busy -> ignored; exactly one done per accepted start.
